// File: rtl/shared_bus_initiator.sv
// rtl/shared_bus_initiator.sv - snooping shared-bus initiator FSM with HITM backoff/retry and snoop timeout
// Optional SHARED_BUS_STATS_EN adds saturating transaction/retry/timeout counters.
module shared_bus_initiator #(
    parameter int ADDR_W        = 32,
    parameter int LINE_W        = 512,
    parameter int SNOOP_TIMEOUT = 15,
    parameter int MAX_RETRY     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [1:0]        rsp_result,
    output logic [LINE_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic [7:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [LINE_W-1:0] bus_wdata,
    output logic              bus_wdata_oe,
    input  logic [LINE_W-1:0] bus_rdata,
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_result
`ifdef SHARED_BUS_STATS_EN
    ,
    output logic [31:0]       stat_txn,
    output logic [31:0]       stat_hitm_retry,
    output logic [31:0]       stat_timeout
`endif
);

    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_INVAL  = 2'd3;
    localparam logic [1:0] SNP_HIT   = 2'b00;
    localparam logic [1:0] SNP_HITM  = 2'b01;
    localparam logic [1:0] SNP_NOHIT = 2'b10;

    localparam int CNT_W   = (SNOOP_TIMEOUT < 1) ? 1 : $clog2(SNOOP_TIMEOUT + 1);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SNOOP,
        BACKOFF,
        DATA,
        RESP
    } busStateT;

    busStateT           state;
    logic [1:0]         opQ;
    logic [ADDR_W-1:0]  addrQ;
    logic [LINE_W-1:0]  wdataQ;
    logic [RETRY_W-1:0] retryCnt;
    logic [CNT_W-1:0]   snoopCnt;
    logic               backoffCnt;

    function automatic logic [7:0] opChar(input logic [1:0] op);
        case (op)
            2'd0:    return "R";
            2'd1:    return "W";
            2'd2:    return "M";
            default: return "I";
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            opQ          <= '0;
            addrQ        <= '0;
            wdataQ       <= '0;
            retryCnt     <= '0;
            snoopCnt     <= '0;
            backoffCnt   <= 1'b0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_result   <= 2'b00;
            rsp_data     <= '0;
            rsp_timeout  <= 1'b0;
            bus_op       <= 8'h00;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_wdata_oe <= 1'b0;
`ifdef SHARED_BUS_STATS_EN
            stat_txn        <= '0;
            stat_hitm_retry <= '0;
            stat_timeout    <= '0;
`endif
        end else begin
            // Bus drive and the response pulse are single-cycle; each state re-asserts what it needs.
            rsp_valid    <= 1'b0;
            bus_op       <= 8'h00;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_wdata_oe <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        opQ       <= req_op;
                        addrQ     <= req_addr;
                        wdataQ    <= req_wdata;
                        retryCnt  <= '0;
                        req_ready <= 1'b0;
                        bus_op    <= opChar(req_op);
                        bus_addr  <= req_addr;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (opQ == OP_WRITE) begin
                        bus_wdata_oe <= 1'b1;
                        bus_wdata    <= wdataQ;
                        rsp_result   <= SNP_NOHIT;
                        rsp_timeout  <= 1'b0;
                        state        <= DATA;
                    end else begin
                        snoopCnt <= '0;
                        state    <= SNOOP;
                    end
                end
                SNOOP: begin
                    if (snoop_valid && snoop_result == SNP_HITM && retryCnt < RETRY_W'(MAX_RETRY)) begin
                        retryCnt   <= retryCnt + 1'b1;
                        backoffCnt <= 1'b0;
                        state      <= BACKOFF;
`ifdef SHARED_BUS_STATS_EN
                        if (stat_hitm_retry != '1) stat_hitm_retry <= stat_hitm_retry + 1'b1;
`endif
                    end else if (snoop_valid) begin
                        // Exhausted HITM reports 01; the reserved code folds into NOHIT.
                        rsp_result  <= (snoop_result == SNP_HIT || snoop_result == SNP_HITM)
                                       ? snoop_result : SNP_NOHIT;
                        rsp_timeout <= 1'b0;
                        if (opQ == OP_INVAL) begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state <= DATA;
                        end
                    end else if (snoopCnt == CNT_W'(SNOOP_TIMEOUT)) begin
                        rsp_result  <= SNP_NOHIT;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
`ifdef SHARED_BUS_STATS_EN
                        if (stat_timeout != '1) stat_timeout <= stat_timeout + 1'b1;
`endif
                    end else begin
                        snoopCnt <= snoopCnt + 1'b1;
                    end
                end
                BACKOFF: begin
                    if (backoffCnt) begin
                        bus_op   <= opChar(opQ);
                        bus_addr <= addrQ;
                        state    <= ADDR;
                    end else begin
                        backoffCnt <= 1'b1;
                    end
                end
                DATA: begin
                    if (opQ != OP_WRITE) rsp_data <= bus_rdata;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
`ifdef SHARED_BUS_STATS_EN
                    if (stat_txn != '1) stat_txn <= stat_txn + 1'b1;
`endif
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/shared_bus_initiator.md
SHARED_BUS_INITIATOR -- requirements
Module: shared_bus_initiator

Interface
REQ-001 Parameter ADDR_W, default 32: shared-bus address width.
REQ-002 Parameter LINE_W, default 512: cache-line data width.
REQ-003 Parameter SNOOP_TIMEOUT, default 15: maximum cycles spent waiting for a snoop result.
REQ-004 Parameter MAX_RETRY, default 3: maximum reissues after HITM.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid / req_ready  in/out  1/1  L2-side request handshake.
REQ-008 req_op  in  2  request type: 0 READ, 1 WRITE, 2 RWIM, 3 INVALIDATE.
REQ-009 req_addr / req_wdata  in  ADDR_W/LINE_W  line address and writeback data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_result / rsp_data / rsp_timeout  out  2/LINE_W/1  final snoop result, read data, and timeout flag.
REQ-012 bus_op  out  8  ASCII opcode: 'R', 'W', 'M', 'I'; 8'h00 when idle.
REQ-013 bus_addr / bus_wdata / bus_wdata_oe  out  ADDR_W/LINE_W/1  address, write data, and data drive enable.
REQ-014 bus_rdata  in  LINE_W  shared-bus read data.
REQ-015 snoop_valid / snoop_result  in  1/2  snoop response: 00 HIT, 01 HITM, 10 NOHIT, 11 reserved.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, ADDR, SNOOP, BACKOFF, DATA, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both 1, with op, addr and wdata latched.
REQ-018 IDLE->ADDR on accept; in ADDR, bus_op and bus_addr SHALL be driven for exactly one cycle.
REQ-019 ADDR->SNOOP for READ, RWIM and INVALIDATE; ADDR->DATA for WRITE (no snoop wait).
REQ-020 In SNOOP, a per-transaction counter SHALL count cycles from 0, and snoop_valid SHALL be sampled each cycle.
REQ-021 Snoop HIT or NOHIT: READ/RWIM go to DATA, INVALIDATE goes to RESP.
REQ-022 Snoop HITM with retries < MAX_RETRY: the retry count SHALL increment and the FSM SHALL go to BACKOFF for exactly 2 cycles, then back to ADDR (reissue the same op and address).
REQ-023 Snoop HITM with retries == MAX_RETRY: proceed as for HIT, with rsp_result=01.
REQ-024 Snoop result 11: SHALL be treated as NOHIT.
REQ-025 snoop_valid still 0 when the counter reaches SNOOP_TIMEOUT: go to RESP with rsp_timeout=1 and rsp_result=10, skipping DATA.
REQ-026 DATA SHALL last one cycle: READ/RWIM capture bus_rdata into rsp_data; WRITE asserts bus_wdata_oe=1 with bus_wdata=latched wdata.
REQ-027 In RESP, rsp_valid=1 for one cycle, then the FSM SHALL return to IDLE; WRITE reports rsp_result=10.
REQ-028 rsp_data SHALL hold its value until the next READ/RWIM capture; outside DATA, bus_wdata_oe=0 and bus_wdata=0.
REQ-029 bus_op SHALL be 8'h00 and bus_addr SHALL be 0 in every state except ADDR.
REQ-030 A snoop_valid pulse outside SNOOP SHALL be ignored.
REQ-031 Minimum latency from accept to rsp_valid: READ 4 cycles with snoop in the first SNOOP cycle; WRITE 3 cycles.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_result=00, rsp_data=0, rsp_timeout=0, bus_op=8'h00, bus_addr=0, bus_wdata=0, bus_wdata_oe=0, and zero the retry and timeout counters.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no rsp_valid; the first accept after deassertion SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-034 With SHARED_BUS_STATS_EN defined, the block SHALL add 32-bit outputs stat_txn, stat_hitm_retry and stat_timeout, incremented respectively on each RESP, each HITM-triggered BACKOFF entry, and each timeout, saturating at all ones and reset to 0.
REQ-035 Without SHARED_BUS_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 READ to 0x0000_1040, snoop NOHIT in the first SNOOP cycle, bus_rdata=pattern A -> bus_op='R' for 1 cycle, rsp_valid on cycle 4, rsp_result=10, rsp_data=A.
REQ-037 WRITE to 0x0000_2000 with wdata B -> bus_op='W', then bus_wdata_oe=1 with B for one cycle, rsp_valid on cycle 3.
REQ-038 RWIM with snoop HITM twice then HIT -> 'M' issued 3 times, 2-cycle idle gaps between issues, final rsp_result=00.
REQ-039 INVALIDATE with no snoop_valid -> rsp_valid after 16 SNOOP cycles, rsp_timeout=1, no DATA cycle.
REQ-040 READ with HITM 4 times -> 4 issues, rsp_result=01; with SHARED_BUS_STATS_EN, stat_hitm_retry=3.
REQ-041 rst_n pulled low during BACKOFF -> outputs reach reset values asynchronously, no rsp_valid, next READ completes normally.
